// File: rtl/fpcvt_pkg.sv
// Shared types and sizing helpers for the streaming integer-to-float converter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Holds the converter FSM state encoding and constant functions deriving the
// input width and maximum exponent from the float field widths.
package fpcvt_pkg;

   typedef enum logic [1:0] {
      IDLE,
      NORM,
      ROUND,
      DONE
   } state_t;

   // Input width: significand bits plus one bit per exponent step.
   function automatic int fpcvtInW(input int expW, input int manW);
      return manW + (1 << expW);
   endfunction

   // Largest exponent code.
   function automatic int fpcvtEMax(input int expW);
      return (1 << expW) - 1;
   endfunction

endpackage

// File: rtl/fpcvt_round.sv
// Rounding stage: turns the normalised magnitude window into the final F/E/sat.
// Latency: combinational.
// Backpressure: none (pure function of its inputs).
//
// Build option: define FPCVT_ROUND_EN for round-half-up with carry into the
// exponent and saturation at E_MAX; leave undefined for plain truncation.
//
// Ports:
//   topBits : magnitude window, [MAN_W:1] candidate significand, [0] round bit
//   eIn/sIn : exponent and sign after normalisation
//   sOut/eOut/fOut/sat : final float fields and saturation flag
module fpcvt_round
   import fpcvt_pkg::*;
#(
   parameter int EXP_W = 3,
   parameter int MAN_W = 5
) (
   input  logic [MAN_W:0]   topBits,
   input  logic [EXP_W-1:0] eIn,
   input  logic             sIn,
   output logic             sOut,
   output logic [EXP_W-1:0] eOut,
   output logic [MAN_W-1:0] fOut,
   output logic             sat
);

`ifdef FPCVT_ROUND_EN
   logic [MAN_W:0] fSum;
   logic [EXP_W:0] eSum;

   always_comb begin
      // One guard bit on each sum catches significand wrap and exponent overflow.
      fSum = {1'b0, topBits[MAN_W:1]} + (MAN_W+1)'(topBits[0]);
      eSum = {1'b0, eIn} + (EXP_W+1)'(fSum[MAN_W]);
      sOut = sIn;
      eOut = eIn;
      fOut = fSum[MAN_W-1:0];
      sat  = 1'b0;
      if (fSum[MAN_W]) begin
         fOut = {1'b1, {(MAN_W-1){1'b0}}};
         eOut = eSum[EXP_W-1:0];
      end
      if (eSum[EXP_W]) begin
         eOut = '1;
         fOut = '1;
         sat  = 1'b1;
      end
   end
`else
   // Round bit is ignored when truncating.
   logic unusedRoundBit;
   assign unusedRoundBit = topBits[0];
   assign sOut = sIn;
   assign eOut = eIn;
   assign fOut = topBits[MAN_W:1];
   assign sat  = 1'b0;
`endif

endmodule

// File: rtl/fpcvt_stream.sv
// Streaming two's-complement to sign/exponent/significand converter, one normalising shift per cycle.
// Latency: n+3 cycles from accept (n = shifts, 0..E_MAX); 1 cycle for the most-negative input.
// Backpressure: single sample in flight; in_ready only in IDLE, result held in DONE until out_ready.
//
// Build option: FPCVT_ROUND_EN selects round-half-up (see fpcvt_round); default truncates.
//
// Ports:
//   clk, rst_n            : rising-edge clock, synchronous active-low reset
//   in_valid/in_ready     : input handshake, in_data sampled only on accept
//   out_valid/out_ready   : output handshake, outputs stable while out_valid && !out_ready
//   out_s/out_e/out_f     : sign, exponent, significand
//   out_sat               : result saturated
module fpcvt_stream
   import fpcvt_pkg::*;
#(
   parameter int EXP_W = 3,
   parameter int MAN_W = 5
) (
   input  logic                                clk,
   input  logic                                rst_n,
   input  logic                                in_valid,
   output logic                                in_ready,
   input  logic [fpcvtInW(EXP_W, MAN_W)-1:0]   in_data,
   output logic                                out_valid,
   input  logic                                out_ready,
   output logic                                out_s,
   output logic [EXP_W-1:0]                    out_e,
   output logic [MAN_W-1:0]                    out_f,
   output logic                                out_sat
);

   localparam int IN_W  = fpcvtInW(EXP_W, MAN_W);
   localparam int E_MAX = fpcvtEMax(EXP_W);
   localparam logic [EXP_W-1:0] E_TOP = EXP_W'(E_MAX);

   state_t state, stateNext;

   logic [IN_W-2:0]  mag;
   logic [EXP_W-1:0] expo;
   logic             sign;

   logic             accept;
   logic             mostNeg;
   logic             normDone;
   logic [IN_W-2:0]  absLow;

   logic             rSign;
   logic [EXP_W-1:0] rExp;
   logic [MAN_W-1:0] rMan;
   logic             rSat;

   assign in_ready  = (state == IDLE) && rst_n;
   assign out_valid = (state == DONE);
   assign accept    = in_valid && in_ready;

   // The most-negative value has no positive counterpart in IN_W bits.
   assign mostNeg  = (in_data == {1'b1, {(IN_W-1){1'b0}}});
   assign absLow   = in_data[IN_W-1] ? (IN_W-1)'(-in_data) : in_data[IN_W-2:0];
   // Stop on a leading one, or at E == 0 (subnormal: no further scaling).
   assign normDone = mag[IN_W-2] || (expo == '0);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= stateNext;
      end
   end

   always_comb begin
      stateNext = state;
      case (state)
         IDLE:    if (accept) stateNext = mostNeg ? DONE : NORM;
         NORM:    if (normDone) stateNext = ROUND;
         ROUND:   stateNext = DONE;
         DONE:    if (out_ready) stateNext = IDLE;
         default: stateNext = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         mag     <= '0;
         expo    <= '0;
         sign    <= 1'b0;
         out_s   <= 1'b0;
         out_e   <= '0;
         out_f   <= '0;
         out_sat <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  sign <= in_data[IN_W-1];
                  mag  <= absLow;
                  expo <= E_TOP;
                  if (mostNeg) begin
                     out_s   <= 1'b1;
                     out_e   <= E_TOP;
                     out_f   <= '1;
                     out_sat <= 1'b1;
                  end
               end
            end
            NORM: begin
               if (!normDone) begin
                  mag  <= {mag[IN_W-3:0], 1'b0};
                  expo <= expo - EXP_W'(1);
               end
            end
            ROUND: begin
               out_s   <= rSign;
               out_e   <= rExp;
               out_f   <= rMan;
               out_sat <= rSat;
            end
            default: ;
         endcase
      end
   end

   fpcvt_round #(
      .EXP_W (EXP_W),
      .MAN_W (MAN_W)
   ) uRound (
      .topBits (mag[IN_W-2 -: MAN_W+1]),
      .eIn     (expo),
      .sIn     (sign),
      .sOut    (rSign),
      .eOut    (rExp),
      .fOut    (rMan),
      .sat     (rSat)
   );

endmodule

// File: tb/tb_fpcvt_stream.sv
// Directed bench for fpcvt_stream at default parameters with a value-level reference model.
module tb_fpcvt_stream;

`ifdef FPCVT_ROUND_EN
   localparam bit RND = 1'b1;
`else
   localparam bit RND = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [12:0] in_data;
   logic        out_valid;
   logic        out_ready;
   logic        out_s;
   logic [2:0]  out_e;
   logic [4:0]  out_f;
   logic        out_sat;

   int nChecks = 0;
   int nPass   = 0;

   // Expected result of the sample currently in flight.
   logic       expPending = 1'b0;
   logic [9:0] expWord    = '0;
   logic       checkOn    = 1'b0;

   always #5 clk = ~clk;

   fpcvt_stream dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_s     (out_s),
      .out_e     (out_e),
      .out_f     (out_f),
      .out_sat   (out_sat)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      nChecks++;
      if (act === exp) nPass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
   endtask

   // Reference: value = F * 2^E. Scale |x| up by the largest power of two
   // (at most E_MAX) that keeps it below 2^12, then take the top 5 bits.
   task automatic model(input logic [12:0] x, output int s, output int e, output int f,
                        output int sat, output int lat);
      int v, m, n, scaled, r;
      v = int'($signed(x));
      if (v == -4096) begin
         s = 1; e = 7; f = 31; sat = 1; lat = 1;
         return;
      end
      s = (v < 0) ? 1 : 0;
      m = (v < 0) ? -v : v;
      n = 0;
      while (n < 7 && m * (1 << n) < 2048) n++;
      scaled = m * (1 << n);
      f   = scaled / 128;
      r   = (scaled / 64) % 2;
      e   = 7 - n;
      sat = 0;
      if (RND) begin
         f = f + r;
         if (f == 32) begin f = 16; e = e + 1; end
         if (e > 7) begin e = 7; f = 31; sat = 1; end
      end
      lat = n + 3;
   endtask

   // Compare process: every cycle the output is valid it must equal the model.
   always @(negedge clk) begin
      if (checkOn && out_valid) begin
         if (expPending) begin
            check("out_fields", {out_s, out_e, out_f, out_sat}, expWord);
            check("in_ready_busy", in_ready, 0);
         end else begin
            check("unexpected_valid", out_valid, 0);
         end
      end
   end

   task automatic runOne(input logic [12:0] x, input int hold, input bit lit,
                         input int ls, input int le, input int lf, input int lsat, input int llat);
      int s, e, f, sat, lat, cnt;
      model(x, s, e, f, sat, lat);
      if (lit) begin
         check("lit_model", {s[0], e[2:0], f[4:0], sat[0]},
               {ls[0], le[2:0], lf[4:0], lsat[0]});
         check("lit_lat_model", lat, llat);
      end
      check("in_ready_idle", in_ready, 1);
      expWord    = {s[0], e[2:0], f[4:0], sat[0]};
      expPending = 1'b1;
      in_data    = x;
      in_valid   = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      in_data  = 13'($urandom);
      cnt = 1;
      while (!out_valid && cnt < 20) begin
         @(negedge clk);
         cnt++;
      end
      check("latency", cnt, lat);
      if (lit) check("lit_dut", {out_s, out_e, out_f, out_sat},
                     {ls[0], le[2:0], lf[4:0], lsat[0]});
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         check("hold_valid", out_valid, 1);
      end
      out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      out_ready  = 1'b0;
      expPending = 1'b0;
      check("valid_dropped", out_valid, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end

   initial begin
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_data   = '0;
      out_ready = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_in_ready", in_ready, 0);
      check("rst_out_valid", out_valid, 0);
      check("rst_fields", {out_s, out_e, out_f, out_sat}, 0);
      rst_n = 1'b1;
      @(negedge clk);
      checkOn = 1'b1;

      // Directed vectors: x, hold, literal?, S, E, F, sat, latency
      runOne(13'd0,      0, 1, 0, 0, 0, 0, 10);
      runOne(13'h1000,   0, 1, 1, 7, 31, 1, 1);
      runOne(13'd57,     5, 1, 0, 1, RND ? 29 : 28, 0, 9);
      runOne(13'd63,     0, 1, 0, RND ? 2 : 1, RND ? 16 : 31, 0, 9);
      runOne(-13'sd63,   0, 1, 1, RND ? 2 : 1, RND ? 16 : 31, 0, 9);
      runOne(13'd4095,   0, 1, 0, 7, 31, RND ? 1 : 0, 3);
      runOne(13'd1,      0, 1, 0, 0, 1, 0, 10);
      runOne(13'h1FFF,   0, 1, 1, 0, 1, 0, 10);
      runOne(13'd100,    2, 1, 0, 2, 25, 0, 8);
      runOne(13'd4000,   0, 1, 0, 7, 31, 0, 3);
      runOne(13'd2047,   0, 1, 0, RND ? 7 : 6, RND ? 16 : 31, 0, 4);
      // Model-only vectors.
      runOne(-13'sd4095, 0, 0, 0, 0, 0, 0, 0);
      runOne(13'd200,    1, 0, 0, 0, 0, 0, 0);
      runOne(-13'sd1000, 0, 0, 0, 0, 0, 0, 0);
      runOne(13'd1234,   3, 0, 0, 0, 0, 0, 0);
      runOne(13'd33,     0, 0, 0, 0, 0, 0, 0);

      // Reset while normalising: result discarded, IDLE on the next edge.
      in_data  = 13'd0;
      in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      repeat (3) @(negedge clk);
      check("mid_norm_no_valid", out_valid, 0);
      rst_n = 1'b0;
      @(negedge clk);
      check("mid_rst_out_valid", out_valid, 0);
      check("mid_rst_in_ready", in_ready, 0);
      check("mid_rst_fields", {out_s, out_e, out_f, out_sat}, 0);
      rst_n = 1'b1;
      @(negedge clk);
      check("post_rst_in_ready", in_ready, 1);
      runOne(13'd57,     0, 1, 0, 1, RND ? 29 : 28, 0, 9);

      $display("%0d/%0d checks passed", nPass, nChecks);
      $finish;
   end

endmodule

// File: doc/fpcvt_stream.md
# fpcvt_stream

Parametrised, handshaked successor to the combinational 13-bit two's-complement-to-float converter. Converts a signed integer of width IN_W into a sign / EXP_W-bit exponent / MAN_W-bit significand float, where value ≈ F × 2^E. Normalisation is iterative, with one shift per cycle, so the block trades latency for area. It sits between a sample source and a consumer, using valid/ready on both sides.

## Interface
Parameters:
- EXP_W, default 3: exponent width; E_MAX = 2^EXP_W − 1.
- MAN_W, default 5: significand width.
- IN_W: localparam, MAN_W + 2^EXP_W (13 at defaults); not overridable.

Ports:
- clk, input, 1: rising-edge clock.
- rst_n, input, 1: reset, synchronous, active-low.
- in_valid, input, 1: input sample valid.
- in_ready, output, 1: block can accept.
- in_data, input, IN_W: two's-complement sample.
- out_valid, output, 1: result valid.
- out_ready, input, 1: consumer accepts.
- out_s, output, 1: sign.
- out_e, output, EXP_W: exponent.
- out_f, output, MAN_W: significand.
- out_sat, output, 1: result was saturated.

## Operation
- FSM states: IDLE, NORM, ROUND, DONE.
- in_ready = (state == IDLE). It is forced 0 while rst_n is low.
- **IDLE:** an accept (in_valid && in_ready) does the following:
  - Captures S = in_data[IN_W−1], mag = |in_data|, E = E_MAX.
  - If in_data == 1 followed by IN_W−1 zeros (most negative value), go directly to DONE with S=1, E=E_MAX, F=all ones, sat=1.
  - Otherwise go to NORM.
- **NORM:** each cycle, if mag[IN_W−2] == 1 or E == 0, go to ROUND. Otherwise mag <<= 1 and E −= 1.
- **ROUND:**
  - F = mag[IN_W−2 −: MAN_W]; the round bit is r = mag[IN_W−2−MAN_W].
  - If r is set, F += 1.
  - If F then wraps to 0: set F = 1 followed by MAN_W−1 zeros and E += 1.
  - If E then wraps past E_MAX: set E=E_MAX, F=all ones, sat=1.
  - Next state is DONE.
- **DONE:** out_valid=1. Outputs hold stable until out_ready is sampled high, then the FSM returns to IDLE.
- Zero input: mag never normalises. E reaches 0 and the result is S=0, E=0, F=0.
- Once E reaches 0, bits shifted into mag are zero, so the round bit is 0. This is the subnormal region.

## Timing
- Reset values: state IDLE, out_valid 0, out_s 0, out_e 0, out_f 0, out_sat 0, and all internal registers 0.
- Latency, from the accept edge t to the first cycle with out_valid high, is n+3 cycles. n is the number of shifts, 0..E_MAX.
  - Maximum latency is E_MAX+3 (10 at defaults).
  - Most-negative input: latency is 1.
- Throughput: one result per (latency + 1) cycles at best. The next accept can occur in the cycle after out_valid && out_ready.
- in_data is sampled only on the accept edge. Changes afterwards are ignored.
- Reset asserted in any state: IDLE and out_valid=0 on the next edge. Any in-flight result is discarded.
- out_valid must not drop without out_ready. No combinational path exists from out_ready to in_ready.

## Configuration
- Macro: FPCVT_ROUND_EN.
- Defined: round-half-up as described in ROUND. Carry and saturation paths are present.
- Undefined: truncation, with F = mag[IN_W−2 −: MAN_W] and the r bit ignored. out_sat is asserted only for the most-negative input. The ROUND state still exists, so latency is unchanged.

## Structure
- Package fpcvt_pkg holds:
  - the FSM state enum (state_t);
  - helper functions computing IN_W and E_MAX from EXP_W/MAN_W.
- Sub-module fpcvt_round (combinational) takes mag, E and S, and produces F, E, sat. It contains the increment, carry and saturation logic and owns the FPCVT_ROUND_EN switch.

## Test plan
All scenarios use default parameters.
- in_data=0 → S0 E0 F0 sat0. out_valid exactly 10 cycles after accept.
- in_data=13'h1000 → S1 E7 F31 sat1. out_valid 1 cycle after accept.
- in_data=57 → E1 F29 with FPCVT_ROUND_EN, or E1 F28 without it. out_valid 9 cycles after accept.
- in_data=63 → E2 F16 (round carry). in_data=−63 → S1 E2 F16.
- in_data=4095 → E7 F31 sat1 (round overflow saturates). Without FPCVT_ROUND_EN → E7 F31 sat0.
- Hold out_ready low 5 cycles in DONE → outputs stable and in_ready 0. Assert rst_n low mid-NORM → IDLE with out_valid 0 on the next edge.
